dcache_controller: RTL
======================

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 10, word-address width.
REQ-003 SHALL have parameter LINES, default 16, number of direct-mapped lines (power of 2).
REQ-004 SHALL have parameter WORDS, default 4, words per line (power of 2, at least 2).
REQ-005 SHALL have ports: clk input 1 clock; reset input 1 synchronous active-low reset (one clock; reset synchronous, active-low).
REQ-006 SHALL have core-side ports: mem_read input 1 load request; mem_write input 1 store request; WordAddress input ADDR_W word address; DataIn input DATA_W store data; DataOut output DATA_W load data; stall output 1 core hold.
REQ-007 SHALL have memory-side ports: m_req output 1 request; m_we output 1 write strobe; m_addr output ADDR_W word address; m_wdata output DATA_W write data; m_rdata input DATA_W read data; m_ack input 1 single-cycle completion.

Function
REQ-008 SHALL split WordAddress as offset = low log2(WORDS) bits, index = next log2(LINES) bits, tag = remaining bits.
REQ-009 SHALL be write-through and no-write-allocate, with one valid bit and tag per line.
REQ-010 SHALL use FSM states IDLE, REFILL, WRITE, DONE.
REQ-011 In IDLE, a read hit SHALL drive DataOut combinationally in the same cycle with stall=0 (zero-stall hit).
REQ-012 In IDLE, a read miss SHALL assert stall combinationally, clear the word counter, and enter REFILL.
REQ-013 REFILL SHALL issue m_req=1, m_we=0, m_addr={tag,index,counter}; on each m_ack it SHALL store m_rdata into the line and increment the counter; after ack of word WORDS-1 it SHALL set valid and tag and enter DONE.
REQ-014 In IDLE, mem_write SHALL assert stall and enter WRITE; WRITE SHALL hold m_req=1, m_we=1, m_addr=WordAddress, m_wdata=DataIn until m_ack, then enter DONE; on a hit it SHALL update the cached word in the ack cycle.
REQ-015 In DONE, stall SHALL be 0, DataOut SHALL show the requested word, and the next state SHALL be IDLE.
REQ-016 stall SHALL be 1 in REFILL and WRITE; the core SHALL hold its request stable while stall=1.
REQ-017 If mem_read and mem_write are both 1, the controller SHALL treat the request as a write.
REQ-018 m_ack received in IDLE or DONE SHALL be ignored.
REQ-019 The word counter SHALL wrap from WORDS-1 to 0.
REQ-020 With no request, DataOut SHALL be 0 and stall SHALL be 0.

Reset
REQ-021 When reset=0 at a clk edge, the controller SHALL enter IDLE, clear all valid bits and the counter, and drive m_req=0, m_we=0, stall=0, DataOut=0, m_addr=0, m_wdata=0.
REQ-022 A reset during REFILL or WRITE SHALL abort the transfer, leaving the partial line invalid.

Configuration
REQ-023 With DCACHE_STATS_EN defined, the controller SHALL add outputs hit_count and miss_count (16 bits each, reset to 0, saturating at 0xFFFF), incremented once per read hit in IDLE and once per read-miss entry to REFILL.
REQ-024 Without DCACHE_STATS_EN, those ports and counters SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-025 Package dcache_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-026 Tag/valid/data storage SHALL be one sub-module, dcache_array, with one write port and one combinational read port.

Verification
REQ-027 Defaults, memory ack latency 2: read 0x040 cold -> stall=1, m_addr 0x040..0x043 issued in order, DONE returns mem[0x040]; stall low 1 cycle after 4th ack.
REQ-028 After REQ-027, read 0x042 -> same-cycle DataOut=mem[0x042], stall=0, m_req=0.
REQ-029 Write 0xDEADBEEF to 0x041 (hit) -> one m_we=1 transaction; a following read of 0x041 hits and returns 0xDEADBEEF.
REQ-030 Write to 0x200 (miss) then read 0x200 -> write-through only, line not allocated; the read misses and refills 0x200..0x203.
REQ-031 Assert reset=0 after the 2nd ack of a refill -> m_req=0 next edge; a re-read of the same address misses again.
REQ-032 With DCACHE_STATS_EN: run REQ-027 and REQ-028 -> miss_count=1, hit_count=1; force 0xFFFF then a hit -> stays 0xFFFF.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and default constants for the direct-mapped write-through data cache.
package dcache_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_LINES  = 16;
    localparam int DEF_WORDS  = 4;
    localparam int STAT_W     = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: one write port (word + valid/tag update), one combinational read port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = 4,
    parameter int LINES  = DEF_LINES,
    parameter int WORDS  = DEF_WORDS,
    localparam int IDX_W = $clog2(LINES),
    localparam int OFF_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              set_valid,
    input  logic              clr_valid,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [OFF_W-1:0]  wr_offset,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [OFF_W-1:0]  rd_offset,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data
);

    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][WORDS];

    always_comb begin
        valid_d = valid_q;
        if (clr_valid) valid_d[wr_index] = 1'b0;
        if (set_valid) valid_d[wr_index] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // Tag and data carry no reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (set_valid) tag_q[wr_index] <= wr_tag;
        if (we)        data_q[wr_index][wr_offset] <= wr_data;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Optional DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINES  = DEF_LINES,
    parameter int WORDS  = DEF_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] WordAddress,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
`endif
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    logic [OFF_W-1:0]  offset;
    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    assign offset = WordAddress[OFF_W-1:0];
    assign index  = WordAddress[OFF_W +: IDX_W];
    assign tag    = WordAddress[ADDR_W-1 -: TAG_W];

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit, read_req, last_word;
    logic              arr_we, arr_set_valid, arr_clr_valid;
    logic [OFF_W-1:0]  arr_offset;
    logic [DATA_W-1:0] arr_wdata;

    assign hit       = rd_valid && (rd_tag == tag);
    assign read_req  = mem_read && !mem_write;
    assign last_word = (cnt_q == OFF_W'(WORDS - 1));

    dcache_array #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W),
        .LINES  (LINES),
        .WORDS  (WORDS)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .we        (arr_we),
        .set_valid (arr_set_valid),
        .clr_valid (arr_clr_valid),
        .wr_index  (index),
        .wr_offset (arr_offset),
        .wr_data   (arr_wdata),
        .wr_tag    (tag),
        .rd_index  (index),
        .rd_offset (offset),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_write) begin
                    state_d = WRITE;
                end else if (mem_read && !hit) begin
                    state_d = REFILL;
                    cnt_d   = '0;
                end
            end
            REFILL: begin
                if (m_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_word) state_d = DONE;
                end
            end
            WRITE:   if (m_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall         = 1'b0;
        DataOut       = '0;
        m_req         = 1'b0;
        m_we          = 1'b0;
        m_addr        = '0;
        m_wdata       = '0;
        arr_we        = 1'b0;
        arr_set_valid = 1'b0;
        arr_clr_valid = 1'b0;
        arr_offset    = offset;
        arr_wdata     = DataIn;
        case (state_q)
            IDLE: begin
                stall = mem_write || (mem_read && !hit);
                if (read_req && hit) DataOut = rd_data;
                // The victim line is dropped up front so an aborted refill never looks valid.
                arr_clr_valid = read_req && !hit;
            end
            REFILL: begin
                stall      = 1'b1;
                m_req      = 1'b1;
                m_addr     = {tag, index, cnt_q};
                arr_offset = cnt_q;
                arr_wdata  = m_rdata;
                arr_we     = m_ack;
                arr_set_valid = m_ack && last_word;
            end
            WRITE: begin
                stall   = 1'b1;
                m_req   = 1'b1;
                m_we    = 1'b1;
                m_addr  = WordAddress;
                m_wdata = DataIn;
                arr_we  = m_ack && hit;
            end
            DONE: begin
                if (mem_read && hit) DataOut = rd_data;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [STAT_W-1:0] hit_count_q, hit_count_d;
    logic [STAT_W-1:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == IDLE && read_req) begin
            if (hit) hit_count_d  = sat_inc(hit_count_q);
            else     miss_count_d = sat_inc(miss_count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
